// File: rtl/osc_timebase_pkg.sv
// Shared types and constants for the oscillator timebase.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package osc_timebase_pkg;

    localparam int PERIOD_W_DEF = 16;   // default symbol-period width, tick_pre units
    localparam int SYM_CNT_W    = 8;    // completed-symbol counter width (wraps)

    typedef enum logic [0:0] {
        WAIT = 1'b0,                    // oscillator settling, timebase idle
        RUN  = 1'b1                     // timebase active
    } state_e;

endpackage

// File: rtl/osc_timebase_if.sv
// Control/strobe bundle between the timebase and its consumer.
// Latency: n/a (wires only).
// Backpressure: none; period_load is a one-cycle request answered by period_ack.
//
// master: consumer side (drives run / period_in / period_load)
// slave : timebase side (drives period_ack / ready / tick_pre / tick_sym / sym_cnt)
interface osc_timebase_if
    import osc_timebase_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
);
    logic                 run;
    logic [PERIOD_W-1:0]  period_in;
    logic                 period_load;
    logic                 period_ack;
    logic                 ready;
    logic                 tick_pre;
    logic                 tick_sym;
    logic [SYM_CNT_W-1:0] sym_cnt;

    modport master (
        output run, period_in, period_load,
        input  period_ack, ready, tick_pre, tick_sym, sym_cnt
    );

    modport slave (
        input  run, period_in, period_load,
        output period_ack, ready, tick_pre, tick_sym, sym_cnt
    );

endinterface

// File: rtl/osc_timebase_mod_counter.sv
// Modulo counter 0..modulus-1 with enable, synchronous clear and wrap strobe.
// Latency: value updates on the clock edge; wrap is combinational from the current value.
// Backpressure: none; clr overrides en.
//
// Ports: clk, rst (async active-high), en, clr, modulus (>=1),
//        value (current count), wrap (high in the cycle whose edge returns value to 0).
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] value,
    output logic         wrap
);

    // ">=" rather than "==" so a modulus that shrinks under a live count
    // still wraps on the next step instead of running the full range.
    assign wrap = en && !clr && (value >= (modulus - W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= wrap ? '0 : (value + W'(1));
        end
    end

endmodule

// File: rtl/osc_timebase.sv
// Transmitter timebase on the oscillator clock: startup hold-off, prescaler strobe, symbol strobe.
// Latency: ready after STARTUP_CYCLES edges; tick_pre registered; tick_sym coincident with tick_pre.
// Backpressure: none; period loads are always accepted and acknowledged one cycle later.
//
// Ports: clk (oscillator clock), rst (async active-high),
//        bus (slave): run, period_in, period_load -> period_ack, ready, tick_pre, tick_sym, sym_cnt.
module osc_timebase
    import osc_timebase_pkg::*;
#(
    parameter int STARTUP_CYCLES = 1024,
    parameter int PRE_DIV        = 21,
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic          clk,
    input  logic          rst,
    osc_timebase_if.slave bus
);

    localparam int SU_W  = $clog2(STARTUP_CYCLES);
    localparam int PRE_W = $clog2(PRE_DIV + 1);

    localparam logic [0:0] ST_WAIT = WAIT;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]           state;
    logic [SU_W-1:0]      su_cnt;
    logic                 running;

    logic [PRE_W-1:0]     pre_val;
    logic                 pre_wrap;
    logic                 tick_pre_q;

    logic [PERIOD_W-1:0]  active_per;
    logic [PERIOD_W-1:0]  pend_per;
    logic                 pend_vld;
    logic                 ack_q;

    logic [PERIOD_W-1:0]  sym_val;
    logic                 sym_wrap;
    logic [SYM_CNT_W-1:0] sym_cnt_q;

    assign running = (state == ST_RUN);

    // Startup hold-off: count edges after reset release, then enter RUN for good.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_WAIT;
            su_cnt <= '0;
        end else if (state == ST_WAIT) begin
            su_cnt <= su_cnt + SU_W'(1);
            if (su_cnt == SU_W'(STARTUP_CYCLES - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Prescaler free-runs once settled; its wrap is registered into tick_pre,
    // which lands tick_pre exactly PRE_DIV cycles after ready.
    mod_counter #(.W(PRE_W)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .clr     (1'b0),
        .modulus (PRE_W'(PRE_DIV)),
        .value   (pre_val),
        .wrap    (pre_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_pre_q <= 1'b0;
        end else begin
            tick_pre_q <= pre_wrap;
        end
    end

    // Symbol counter steps on tick_pre; dropping run throws away a partial symbol.
    mod_counter #(.W(PERIOD_W)) u_sym (
        .clk     (clk),
        .rst     (rst),
        .en      (tick_pre_q && bus.run),
        .clr     (!bus.run),
        .modulus (active_per),
        .value   (sym_val),
        .wrap    (sym_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q <= '0;
        end else if (sym_wrap) begin
            sym_cnt_q <= sym_cnt_q + SYM_CNT_W'(1);
        end
    end

    // Period handshake. While the symbol counter is idle (WAIT or run=0) the
    // pending value goes live the cycle after capture; while counting it waits
    // for a symbol boundary so no symbol is ever cut short. A load captured on
    // a wrap edge only sets pend_vld afterwards, so it takes the next wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_per <= PERIOD_W'(DEFAULT_PERIOD);
            pend_per   <= '0;
            pend_vld   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= bus.period_load;
            if (pend_vld && (!running || !bus.run || sym_wrap)) begin
                active_per <= pend_per;
                pend_vld   <= 1'b0;
            end
            // A zero period is meaningless; treat it as one tick per symbol.
            if (bus.period_load) begin
                pend_per <= (bus.period_in == '0) ? PERIOD_W'(1) : bus.period_in;
                pend_vld <= 1'b1;
            end
        end
    end

    // Counter values are not exported; fold them so they read as deliberately unused.
    logic unused_ok;
    assign unused_ok = ^{pre_val, sym_val};

    assign bus.ready      = running;
    assign bus.tick_pre   = tick_pre_q;
    assign bus.tick_sym   = sym_wrap;
    assign bus.sym_cnt    = sym_cnt_q;
    assign bus.period_ack = ack_q;

endmodule
